// File: rtl/fpu_pkg.sv
// Shared definitions for the multiplier result path: flag bit positions,
// special binary32 encodings, the buffered entry layout and the packing rule.
package fpu_pkg;

  localparam int FLG_INV = 4;
  localparam int FLG_OVF = 3;
  localparam int FLG_UNF = 2;
  localparam int FLG_INX = 1;
  localparam int FLG_ZER = 0;

  localparam logic [31:0] QNAN_32 = 32'h7FC00000;
  localparam logic [7:0]  EXP_INF = 8'hFF;

  typedef struct packed {
    logic [31:0] word;
    logic [4:0]  flags;
  } result_entry_t;

  localparam int ENTRY_W = $bits(result_entry_t);

  // Invalid beats zero beats overflow; NaN drops the sign, zero/inf keep it.
  function automatic logic [31:0] pack_word(input logic       inv,
                                            input logic       zer,
                                            input logic       ovf,
                                            input logic       sz,
                                            input logic [7:0] ez,
                                            input logic [22:0] frac);
    if (inv)      return QNAN_32;
    else if (zer) return {sz, 31'b0};
    else if (ovf) return {sz, EXP_INF, 23'b0};
    else          return {sz, ez, frac};
  endfunction

endpackage

// File: rtl/fpu_mul_result_buffer_if.sv
// Valid/ready bundle between the multiplier, the result buffer and its consumer.
interface fpu_mul_result_buffer_if;

  logic        in_valid;
  logic        in_ready;
  logic [23:0] mz;
  logic [7:0]  ez;
  logic        sz;
  logic [4:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  out_flags;

  modport slave (
    input  in_valid, mz, ez, sz, in_flags, out_ready,
    output in_ready, out_valid, result, out_flags
  );

  modport master (
    output in_valid, mz, ez, sz, in_flags, out_ready,
    input  in_ready, out_valid, result, out_flags
  );

endinterface

// File: rtl/fpu_sync_fifo.sv
// Small synchronous FIFO with occupancy count; head entry is always visible on rdata.
module fpu_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  // Entries are cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PTR_W'(1);
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/fpu_mul_result_buffer.sv
// Packs multiplier results into binary32, buffers them behind valid/ready,
// and accumulates software-clearable sticky exception flags.
module fpu_mul_result_buffer
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  fpu_mul_result_buffer_if.slave   bus,
  input  logic                     clear_flags,
  output logic [4:0]               sticky_flags,
  output logic [PTR_W:0]           count
);

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  result_entry_t wr_entry;
  result_entry_t rd_entry;

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  always_comb begin
    wr_entry.word  = pack_word(bus.in_flags[FLG_INV], bus.in_flags[FLG_ZER],
                               bus.in_flags[FLG_OVF], bus.sz, bus.ez, bus.mz[22:0]);
    wr_entry.flags = bus.in_flags;
  end

  fpu_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus.result    = rd_entry.word;
  assign bus.out_flags = rd_entry.flags;

  // A push coinciding with a clear survives the clear.
  always_ff @(posedge clk) begin
    if (rst) sticky_flags <= '0;
    else     sticky_flags <= (clear_flags ? 5'b0 : sticky_flags) | (push ? bus.in_flags : 5'b0);
  end

endmodule

// File: tb/tb_fpu_mul_result_buffer.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_fpu_mul_result_buffer;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_flags;
  logic [4:0] sticky_flags;
  logic [1:0] count;

  int checks = 0;
  int errors = 0;

  fpu_mul_result_buffer_if bus();

  fpu_mul_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .clear_flags  (clear_flags),
    .sticky_flags (sticky_flags),
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [4:0]  flags;
  } ref_entry_t;

  ref_entry_t  ref_q[$];
  logic [4:0]  ref_sticky;

  function automatic logic [31:0] ref_word(input logic [4:0] fl, input logic s,
                                           input logic [7:0] e, input logic [23:0] m);
    if (fl[4])      return 32'h7FC00000;
    else if (fl[0]) return {s, 31'b0};
    else if (fl[3]) return {s, 8'hFF, 23'b0};
    return {s, e, m[22:0]};
  endfunction

  function automatic void model_step(input logic r, input logic iv, input logic ordy,
                                     input logic clr, input logic s, input logic [7:0] e,
                                     input logic [23:0] m, input logic [4:0] fl);
    bit do_push;
    bit do_pop;
    if (r) begin
      ref_q.delete();
      ref_sticky = '0;
      return;
    end
    do_push = iv && (ref_q.size() < DEPTH);
    do_pop  = ordy && (ref_q.size() > 0);
    ref_sticky = (clr ? 5'b0 : ref_sticky) | (do_push ? fl : 5'b0);
    if (do_pop) void'(ref_q.pop_front());
    if (do_push) ref_q.push_back('{word: ref_word(fl, s, e, m), flags: fl});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic iv, input logic ordy,
                               input logic clr, input logic s, input logic [7:0] e,
                               input logic [23:0] m, input logic [4:0] fl);
    rst          = r;
    bus.in_valid = iv;
    bus.out_ready = ordy;
    clear_flags  = clr;
    bus.sz       = s;
    bus.ez       = e;
    bus.mz       = m;
    bus.in_flags = fl;
    model_step(r, iv, ordy, clr, s, e, m, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(ref_q.size()));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ref_q.size() != 0));
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(ref_q.size() != DEPTH));
    chk({tag, ".sticky"}, 32'(sticky_flags), 32'(ref_sticky));
    if (ref_q.size() != 0) begin
      chk({tag, ".result"}, bus.result, ref_q[0].word);
      chk({tag, ".out_flags"}, 32'(bus.out_flags), 32'(ref_q[0].flags));
    end
  endtask

  typedef struct {
    string       name;
    logic        iv, ordy, clr, s;
    logic [7:0]  e;
    logic [23:0] m;
    logic [4:0]  fl;
    logic        e_valid, e_ready;
    int          e_count;
    logic [31:0] e_result;
    logic [4:0]  e_oflags, e_sticky;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic iv, input logic ordy,
                              input logic clr, input logic s, input logic [7:0] e,
                              input logic [23:0] m, input logic [4:0] fl,
                              input logic ev, input logic er, input int ec,
                              input logic [31:0] eres, input logic [4:0] eof,
                              input logic [4:0] est);
    vec_t v;
    v.name = nm; v.iv = iv; v.ordy = ordy; v.clr = clr; v.s = s; v.e = e; v.m = m;
    v.fl = fl; v.e_valid = ev; v.e_ready = er; v.e_count = ec; v.e_result = eres;
    v.e_oflags = eof; v.e_sticky = est;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [31:0] exp_w;
    logic [23:0] m;
    logic [7:0]  e;

    vecs.push_back(mk("single_push", 1, 1, 0, 0, 8'h80, 24'hC00000, 5'b00000, 1, 1, 1, 32'h40400000, 5'b00000, 5'b00000));
    vecs.push_back(mk("single_drain", 0, 1, 0, 0, 8'h00, 24'h0, 5'b00000, 0, 1, 0, 32'h0, 5'b0, 5'b00000));
    vecs.push_back(mk("push_nan", 1, 0, 0, 1, 8'h12, 24'h0, 5'b10000, 1, 1, 1, 32'h7FC00000, 5'b10000, 5'b10000));
    vecs.push_back(mk("push_zero_full", 1, 0, 0, 1, 8'h34, 24'h123456, 5'b00001, 1, 0, 2, 32'h7FC00000, 5'b10000, 5'b10001));
    vecs.push_back(mk("push_when_full", 1, 0, 0, 0, 8'h01, 24'h0, 5'b00000, 1, 0, 2, 32'h7FC00000, 5'b10000, 5'b10001));
    vecs.push_back(mk("drain_first", 0, 1, 0, 0, 8'h00, 24'h0, 5'b00000, 1, 1, 1, 32'h80000000, 5'b00001, 5'b10001));
    vecs.push_back(mk("inf_pushpop", 1, 1, 0, 0, 8'h55, 24'h0, 5'b01010, 1, 1, 1, 32'h7F800000, 5'b01010, 5'b11011));
    vecs.push_back(mk("drain_inf", 0, 1, 0, 0, 8'h00, 24'h0, 5'b00000, 0, 1, 0, 32'h0, 5'b0, 5'b11011));
    vecs.push_back(mk("push_unf", 1, 1, 0, 0, 8'h7F, 24'h200000, 5'b00100, 1, 1, 1, 32'h3FA00000, 5'b00100, 5'b11111));
    vecs.push_back(mk("clear_with_push", 1, 1, 1, 1, 8'h81, 24'h0, 5'b00010, 1, 1, 1, 32'hC0800000, 5'b00010, 5'b00010));
    vecs.push_back(mk("drain_last", 0, 1, 0, 0, 8'h00, 24'h0, 5'b00000, 0, 1, 0, 32'h0, 5'b0, 5'b00010));

    applyStimulus(1, 0, 0, 0, 0, 8'h0, 24'h0, 5'b0);
    applyStimulus(1, 0, 0, 0, 0, 8'h0, 24'h0, 5'b0);
    chk("reset.count", 32'(count), 0);
    chk("reset.out_valid", 32'(bus.out_valid), 0);
    chk("reset.in_ready", 32'(bus.in_ready), 1);
    chk("reset.sticky", 32'(sticky_flags), 0);
    chk("reset.result", bus.result, 0);
    chk("reset.out_flags", 32'(bus.out_flags), 0);

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].iv, vecs[i].ordy, vecs[i].clr, vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].fl);
      chk({vecs[i].name, ".out_valid"}, 32'(bus.out_valid), 32'(vecs[i].e_valid));
      chk({vecs[i].name, ".in_ready"}, 32'(bus.in_ready), 32'(vecs[i].e_ready));
      chk({vecs[i].name, ".count"}, 32'(count), 32'(vecs[i].e_count));
      chk({vecs[i].name, ".sticky"}, 32'(sticky_flags), 32'(vecs[i].e_sticky));
      if (vecs[i].e_valid) begin
        chk({vecs[i].name, ".result"}, bus.result, vecs[i].e_result);
        chk({vecs[i].name, ".out_flags"}, 32'(bus.out_flags), 32'(vecs[i].e_oflags));
      end
    end

    // Streaming at count=1: every word must surface the cycle after its push.
    applyStimulus(0, 1, 1, 0, 0, 8'h0A, 24'h000001, 5'b0);
    chk("stream_prime.count", 32'(count), 1);
    for (int i = 0; i < 8; i++) begin
      e = 8'(8'h10 + i);
      m = 24'($urandom);
      exp_w = {1'b0, e, m[22:0]};
      applyStimulus(0, 1, 1, 0, 0, e, m, 5'b0);
      chk($sformatf("stream%0d.count", i), 32'(count), 1);
      chk($sformatf("stream%0d.result", i), bus.result, exp_w);
    end
    applyStimulus(0, 0, 1, 0, 0, 8'h0, 24'h0, 5'b0);
    chk("stream_drain.count", 32'(count), 0);

    // Reset while full with a push in flight.
    applyStimulus(0, 1, 0, 0, 1, 8'h33, 24'h1, 5'b01000);
    applyStimulus(0, 1, 0, 0, 0, 8'h44, 24'h2, 5'b00100);
    chk("pre_rst.count", 32'(count), 2);
    applyStimulus(1, 1, 0, 0, 0, 8'h55, 24'h3, 5'b00010);
    chk("mid_rst.count", 32'(count), 0);
    chk("mid_rst.out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst.in_ready", 32'(bus.in_ready), 1);
    chk("mid_rst.sticky", 32'(sticky_flags), 0);
    chk("mid_rst.result", bus.result, 0);
    chk("mid_rst.out_flags", 32'(bus.out_flags), 0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                    1'($urandom), $urandom_range(0, 15) == 0, 1'($urandom),
                    8'($urandom), 24'($urandom),
                    ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
